// File: rtl/unidade_de_busca.sv
// unidade_de_busca: fetch / PC-sequencing stage of the single-cycle iZero core.
// Owns the PC and drives it to the ROM, decodes j/jal/jr/jf/halt/in for the next PC,
// stalls on `in` until confirmed, and freezes on halt or out-of-range fetch.
// Ports: clock, reset (sync, active-high), instrucao, dado_rs, confirma_entrada ->
//        pc, link, executa, esperando_entrada, parado [, contador].
// Optional: define BUSCA_CONTADOR_EN to add the saturating committed-instruction counter.
module unidade_de_busca #(
    parameter int          MEM_SIZE = 150,
    parameter logic [25:0] RESET_PC = 26'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic [31:0] dado_rs,
    input  logic        confirma_entrada,
    output logic [25:0] pc,
    output logic [25:0] link,
    output logic        executa,
    output logic        esperando_entrada,
`ifdef BUSCA_CONTADOR_EN
    output logic        parado,
    output logic [31:0] contador
`else
    output logic        parado
`endif
);

    typedef enum logic [1:0] {
        EXECUTA,
        ESPERA_ENTRADA,
        PARADO
    } estado_t;

    localparam logic [5:0] OP_J    = 6'b010110;
    localparam logic [5:0] OP_JAL  = 6'b010111;
    localparam logic [5:0] OP_JF   = 6'b010101;
    localparam logic [5:0] OP_HALT = 6'b011000;
    localparam logic [5:0] OP_IN   = 6'b010011;
    localparam logic [5:0] FN_JR   = 6'b010010;

    estado_t     r_estado;
    estado_t     w_estado_prox;
    logic [25:0] r_pc;
    logic [25:0] w_pc_prox;
    logic [25:0] w_pc_inc;
    logic [25:0] w_alvo;
    logic [5:0]  w_op;
    logic        w_is_j;
    logic        w_is_jr;
    logic        w_is_jf;
    logic        w_is_halt;
    logic        w_is_in;
    logic        w_alvo_fora;
    logic        w_inc_fora;
    logic        w_executa;
    logic        w_espera;

    assign w_op      = instrucao[31:26];
    assign w_is_j    = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_is_jr   = (w_op == 6'b000000) && (instrucao[5:0] == FN_JR);
    assign w_is_jf   = (w_op == OP_JF);
    assign w_is_halt = (w_op == OP_HALT);
    assign w_is_in   = (w_op == OP_IN);

    // Wraps modulo 2^26; the range check stops the core before the wrap matters.
    assign w_pc_inc = r_pc + 26'd1;

    always_comb begin
        w_alvo = w_pc_inc;
        unique case (1'b1)
            w_is_j:  w_alvo = instrucao[25:0];
            w_is_jr: w_alvo = dado_rs[25:0];
            w_is_jf: w_alvo = (dado_rs == 32'd0) ? {10'd0, instrucao[15:0]} : w_pc_inc;
            default: w_alvo = w_pc_inc;
        endcase
    end

    assign w_alvo_fora = {6'd0, w_alvo} >= 32'(MEM_SIZE);
    assign w_inc_fora  = {6'd0, w_pc_inc} >= 32'(MEM_SIZE);

    always_comb begin
        w_estado_prox = r_estado;
        w_pc_prox     = r_pc;
        w_executa     = 1'b0;
        w_espera      = 1'b0;
        case (r_estado)
            EXECUTA: begin
                if (w_is_halt) begin
                    w_executa     = 1'b1;
                    w_estado_prox = PARADO;
                end else if (w_is_in && !confirma_entrada) begin
                    w_espera      = 1'b1;
                    w_estado_prox = ESPERA_ENTRADA;
                end else begin
                    // Out-of-range target still commits the current instruction.
                    w_executa = 1'b1;
                    if (w_alvo_fora) begin
                        w_estado_prox = PARADO;
                    end else begin
                        w_pc_prox = w_alvo;
                    end
                end
            end
            ESPERA_ENTRADA: begin
                if (confirma_entrada) begin
                    w_executa = 1'b1;
                    if (w_inc_fora) begin
                        w_estado_prox = PARADO;
                    end else begin
                        w_pc_prox     = w_pc_inc;
                        w_estado_prox = EXECUTA;
                    end
                end else begin
                    w_espera = 1'b1;
                end
            end
            default: begin
                w_estado_prox = PARADO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= EXECUTA;
            r_pc     <= RESET_PC;
        end else begin
            r_estado <= w_estado_prox;
            r_pc     <= w_pc_prox;
        end
    end

`ifdef BUSCA_CONTADOR_EN
    logic [31:0] r_contador;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_contador <= 32'd0;
        end else if (w_executa && (r_contador != 32'hFFFF_FFFF)) begin
            r_contador <= r_contador + 32'd1;
        end
    end

    assign contador = r_contador;
`endif

    assign pc                = r_pc;
    assign link              = w_pc_inc;
    assign executa           = w_executa;
    assign esperando_entrada = w_espera;
    assign parado            = (r_estado == PARADO);

endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca: directed bench for unidade_de_busca.
// The bench plays the ROM and register file, driving instrucao/dado_rs directly.
module tb_unidade_de_busca;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrucao = 32'd0;
    logic [31:0] dado_rs = 32'd0;
    logic        confirma_entrada = 1'b0;
    logic [25:0] pc;
    logic [25:0] link;
    logic        executa;
    logic        esperando_entrada;
    logic        parado;
`ifdef BUSCA_CONTADOR_EN
    logic [31:0] contador;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    unidade_de_busca #(.MEM_SIZE(150), .RESET_PC(26'd0)) dut (
        .clock            (clock),
        .reset            (reset),
        .instrucao        (instrucao),
        .dado_rs          (dado_rs),
        .confirma_entrada (confirma_entrada),
        .pc               (pc),
        .link             (link),
        .executa          (executa),
        .esperando_entrada(esperando_entrada),
`ifdef BUSCA_CONTADOR_EN
        .parado           (parado),
        .contador         (contador)
`else
        .parado           (parado)
`endif
    );

    function automatic logic [31:0] f_j(input logic [25:0] t);
        return {6'b010110, t};
    endfunction
    function automatic logic [31:0] f_jal(input logic [25:0] t);
        return {6'b010111, t};
    endfunction
    function automatic logic [31:0] f_jr();
        return {6'b000000, 5'd31, 15'd0, 6'b010010};
    endfunction
    function automatic logic [31:0] f_jf(input logic [15:0] t);
        return {6'b010101, 5'd1, 5'd0, t};
    endfunction
    function automatic logic [31:0] f_halt();
        return {6'b011000, 26'd0};
    endfunction
    function automatic logic [31:0] f_in();
        return {6'b010011, 5'd2, 21'd0};
    endfunction
    function automatic logic [31:0] f_nop();
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
    endfunction

    // Advance one clock and settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        confirma_entrada = 1'b0;
        dado_rs = 32'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instrucao = f_j(26'd46);
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (pc !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_pc got %0d want 0", pc);
        end
        vectors++;
        if (link !== 26'd1) begin
            miscompares++;
            $display("FAIL reset_link got %0d want 1", link);
        end
        vectors++;
        if (parado !== 1'b0 || esperando_entrada !== 1'b0 || executa !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_flags got par=%b esp=%b exe=%b want 0 0 1",
                     parado, esperando_entrada, executa);
        end
`ifdef BUSCA_CONTADOR_EN
        vectors++;
        if (contador !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_contador got %0d want 0", contador);
        end
`endif
        tick();
        vectors++;
        if (pc !== 26'd46 || executa !== 1'b1 || parado !== 1'b0) begin
            miscompares++;
            $display("FAIL j46 got pc=%0d exe=%b par=%b want 46 1 0", pc, executa, parado);
        end
    endtask

    task automatic test_jal();
        instrucao = f_j(26'd58);
        tick();
        instrucao = f_jal(26'd1);
        #1;
        vectors++;
        if (link !== 26'd59 || executa !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_link got link=%0d exe=%b want 59 1", link, executa);
        end
        tick();
        vectors++;
        if (pc !== 26'd1) begin
            miscompares++;
            $display("FAIL jal_pc got %0d want 1", pc);
        end
    endtask

    task automatic test_jr();
        instrucao = f_jr();
        dado_rs = 32'd59;
        tick();
        vectors++;
        if (pc !== 26'd59) begin
            miscompares++;
            $display("FAIL jr_pc got %0d want 59", pc);
        end
    endtask

    task automatic test_jf();
        instrucao = f_jf(16'd45);
        dado_rs = 32'd0;
        tick();
        vectors++;
        if (pc !== 26'd45) begin
            miscompares++;
            $display("FAIL jf_taken got %0d want 45", pc);
        end
        dado_rs = 32'd1;
        tick();
        vectors++;
        if (pc !== 26'd46) begin
            miscompares++;
            $display("FAIL jf_not_taken got %0d want 46", pc);
        end
        dado_rs = 32'd0;
    endtask

    task automatic test_in_stall();
        instrucao = f_j(26'd61);
        tick();
        instrucao = f_in();
        confirma_entrada = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (executa !== 1'b0 || esperando_entrada !== 1'b1 || pc !== 26'd61) begin
                miscompares++;
                $display("FAIL in_stall%0d got exe=%b esp=%b pc=%0d want 0 1 61",
                         i, executa, esperando_entrada, pc);
            end
            tick();
        end
        confirma_entrada = 1'b1;
        #1;
        vectors++;
        if (executa !== 1'b1) begin
            miscompares++;
            $display("FAIL in_confirm_exe got %b want 1", executa);
        end
        tick();
        vectors++;
        if (pc !== 26'd62) begin
            miscompares++;
            $display("FAIL in_confirm_pc got %0d want 62", pc);
        end
    endtask

    task automatic test_back_to_back();
        instrucao = f_in();
        confirma_entrada = 1'b1;
        #1;
        vectors++;
        if (esperando_entrada !== 1'b0 || executa !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_flags got esp=%b exe=%b want 0 1", esperando_entrada, executa);
        end
        tick();
        tick();
        vectors++;
        if (pc !== 26'd64) begin
            miscompares++;
            $display("FAIL b2b_pc got %0d want 64", pc);
        end
        confirma_entrada = 1'b0;
    endtask

    task automatic test_in_reset();
        instrucao = f_j(26'd61);
        tick();
        instrucao = f_in();
        confirma_entrada = 1'b0;
        tick();
        vectors++;
        if (esperando_entrada !== 1'b1 || pc !== 26'd61) begin
            miscompares++;
            $display("FAIL inrst_wait got esp=%b pc=%0d want 1 61", esperando_entrada, pc);
        end
        do_reset();
        instrucao = f_nop();
        #1;
        vectors++;
        if (pc !== 26'd0 || esperando_entrada !== 1'b0 || executa !== 1'b1) begin
            miscompares++;
            $display("FAIL inrst_state got pc=%0d esp=%b exe=%b want 0 0 1",
                     pc, esperando_entrada, executa);
        end
        tick();
        vectors++;
        if (pc !== 26'd1) begin
            miscompares++;
            $display("FAIL inrst_run got %0d want 1", pc);
        end
    endtask

    task automatic test_halt();
        instrucao = f_j(26'd70);
        tick();
        instrucao = f_halt();
        #1;
        vectors++;
        if (executa !== 1'b1 || parado !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_commit got exe=%b par=%b want 1 0", executa, parado);
        end
        tick();
        instrucao = f_j(26'd5);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (parado !== 1'b1 || pc !== 26'd70 || executa !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold%0d got par=%b pc=%0d exe=%b want 1 70 0",
                         i, parado, pc, executa);
            end
            tick();
        end
        do_reset();
        #1;
        vectors++;
        if (parado !== 1'b0 || pc !== 26'd0) begin
            miscompares++;
            $display("FAIL halt_reset got par=%b pc=%0d want 0 0", parado, pc);
        end
    endtask

    task automatic test_range();
        instrucao = f_j(26'd149);
        tick();
        instrucao = f_nop();
        #1;
        vectors++;
        if (executa !== 1'b1 || link !== 26'd150) begin
            miscompares++;
            $display("FAIL range_commit got exe=%b link=%0d want 1 150", executa, link);
        end
        tick();
        tick();
        vectors++;
        if (parado !== 1'b1 || pc !== 26'd149 || executa !== 1'b0) begin
            miscompares++;
            $display("FAIL range_seq got par=%b pc=%0d exe=%b want 1 149 0",
                     parado, pc, executa);
        end
        do_reset();
        instrucao = f_j(26'd200);
        tick();
        vectors++;
        if (parado !== 1'b1 || pc !== 26'd0) begin
            miscompares++;
            $display("FAIL range_jump got par=%b pc=%0d want 1 0", parado, pc);
        end
        do_reset();
    endtask

`ifdef BUSCA_CONTADOR_EN
    task automatic test_contador();
        do_reset();
        instrucao = f_nop();
        #1;
        vectors++;
        if (contador !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_clear got %0d want 0", contador);
        end
        for (int i = 0; i < 5; i++) tick();
        instrucao = f_in();
        confirma_entrada = 1'b0;
        tick();
        tick();
        confirma_entrada = 1'b1;
        tick();
        confirma_entrada = 1'b0;
        instrucao = f_halt();
        tick();
        tick();
        tick();
        vectors++;
        if (contador !== 32'd7 || pc !== 26'd6) begin
            miscompares++;
            $display("FAIL cnt_total got cnt=%0d pc=%0d want 7 6", contador, pc);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_jal();
        test_jr();
        test_jf();
        test_in_stall();
        test_back_to_back();
        test_in_reset();
        test_halt();
        test_range();
`ifdef BUSCA_CONTADOR_EN
        test_contador();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unidade_de_busca.md
# unidade_de_busca

- Instruction-fetch/PC-sequencing stage of the single-cycle iZero core.
- Sits directly upstream of the instruction ROM: owns the program counter, drives `pc` into the ROM, and takes the returned `instrucao` back the same cycle.
- Computes the next PC for sequential flow, `j`, `jal`, `jr` and `jf`.
- Sequential control: stalls on `in` until the operator confirms input, and freezes on `halt` or an out-of-range fetch.

## Interface

Parameters:
- `MEM_SIZE`, 150: number of valid ROM words; any next PC ≥ MEM_SIZE is out of range.
- `RESET_PC`, 0: PC loaded on reset.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `instrucao`  in  32  instruction word returned by the ROM for the current `pc`, combinational.
- `dado_rs`  in  32  register-file read of field [25:21] of `instrucao`, combinational.
- `confirma_entrada`  in  1  level; high means the input switches hold valid data.
- `pc`  out  26  current program counter; registered.
- `link`  out  26  `pc + 1`, combinational; the core writes it to $31 on `jal`.
- `executa`  out  1  current instruction commits this cycle; gates register-file and data-memory writes.
- `esperando_entrada`  out  1  high while stalled on `in`.
- `parado`  out  1  high in state PARADO.
- `contador`  out  32  committed-instruction count; present only with `BUSCA_CONTADOR_EN`.

## Operation

Decode uses `op = instrucao[31:26]`. Next-PC rules:
- `j` (010110) and `jal` (010111): `instrucao[25:0]`.
- `jr` (op 000000, funct `instrucao[5:0]` = 010010): `dado_rs[25:0]`.
- `jf` (010101):
  - `dado_rs == 0`: zero-extended `instrucao[15:0]`.
  - otherwise: `pc+1`.
- `halt` (011000): PC holds.
- `in` (010011): `pc+1` once confirmed.
- All other opcodes: `pc+1`.

`pc+1` wraps modulo 2^26 arithmetically; the range check below catches it first.

States:
- EXECUTA
  - Non-`in`, non-`halt` instruction: `executa`=1; `pc` ← next PC.
  - Next PC ≥ MEM_SIZE: `pc` holds; go to PARADO. `executa`=1, so the current instruction still commits.
  - `halt`: `executa`=1; go to PARADO; `pc` holds.
  - `in` with `confirma_entrada`=1: commits; `pc+1`.
  - `in` with `confirma_entrada`=0: `executa`=0; `pc` holds; go to ESPERA_ENTRADA.
- ESPERA_ENTRADA
  - `esperando_entrada`=1; `executa`=0 until `confirma_entrada`=1.
  - On confirm, that cycle: `executa`=1; `pc` ← `pc+1`; back to EXECUTA.
- PARADO
  - `executa`=0; `parado`=1; `pc` frozen.
  - Exit only by `reset`.

Priority: `reset` > everything else. Reset mid-stall or mid-halt returns to EXECUTA at RESET_PC.

## Timing

- Reset values:
  - `pc`=RESET_PC, so `link`=RESET_PC+1.
  - State EXECUTA.
  - `executa` reflects the instruction at RESET_PC.
  - `esperando_entrada`=0, `parado`=0, `contador`=0.
- Latency:
  - Taken jump: target appears on `pc` one cycle after the jump is fetched.
  - No delay slot; no bubbles.
- `executa`, `esperando_entrada`, `link`: combinational from state, `instrucao`, `confirma_entrada`.
- `parado`: registered.
- `confirma_entrada` is level-sensitive. Holding it high across several `in` instructions confirms each one without a stall.

## Configuration

- `BUSCA_CONTADOR_EN` defined:
  - 32-bit `contador` port and register.
  - Increments on every cycle with `executa`=1; saturates at 32'hFFFFFFFF.
  - Cleared by `reset`.
- `BUSCA_CONTADOR_EN` undefined: port and register absent; all other behaviour identical.

## Test plan

- Reset, then `instrucao`=`j 46` at pc 0 → cycle 1: `pc`=46, `executa`=1, `parado`=0.
- `jal 1` at pc 58 → `link`=59 during that cycle, `pc`=1 next.
- `jr $31` with `dado_rs`=59 → `pc`=59 next.
- `jf` target 45:
  - `dado_rs`=0 → `pc`=45.
  - `dado_rs`=1 → `pc`=pc+1.
- `in` at pc 61, `confirma_entrada` low 3 cycles then high:
  - 3 cycles `executa`=0, `esperando_entrada`=1, `pc`=61.
  - 4th cycle `executa`=1; `pc`=62 next.
  - Variant: assert `reset` while stalled → `pc`=0, state EXECUTA.
- `halt` at pc 70 → `parado`=1 and `pc`=70 held for 10 cycles.
- Sequential instruction at pc 149 with MEM_SIZE=150 → PARADO, `pc`=149.
- With `BUSCA_CONTADOR_EN`: `contador` equals the number of committed cycles.
